regfile_wr_sched: RTL and testbench

- Schedules the single register-file write port between several writeback producers, e.g. ALU result, memory load and immediate move.
- Arbitration is round-robin with a valid/ready handshake; the granted write is registered onto the wr_reg bus (ena/adr/data).
- Keeps a per-register busy scoreboard. The decode stage uses it to stall reads of registers whose producing write has not reached the register file (RAW), and to stall a second reservation of a busy register (WAW).

---
 rtl/regfile_wr_sched.sv | 108 ++++++++++
 tb/tb_regfile_wr_sched.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/regfile_wr_sched.sv
// Register-file write-port scheduler: round-robin arbitration across the writeback
// producers, a one-cycle registered write onto wr_reg, and a per-register busy
// scoreboard that drives the decode stage's RAW/WAW stall.
module regfile_wr_sched #(
    parameter int NREQ = 3,
    parameter int DW   = 16,
    parameter int AW   = 3
) (
    input  logic                 clk_i,
    input  logic                 rst_n,
    input  logic [NREQ-1:0]      req_valid_i,
    input  logic [NREQ*AW-1:0]   req_adr_i,
    input  logic [NREQ*DW-1:0]   req_data_i,
    output logic [NREQ-1:0]      req_ready_o,
    output logic                 wr_ena_o,
    output logic [AW-1:0]        wr_adr_o,
    output logic [DW-1:0]        wr_data_o,
    input  logic                 sb_set_i,
    input  logic [AW-1:0]        sb_set_adr_i,
    input  logic                 rd_ena_i,
    input  logic [AW-1:0]        rd_a1_i,
    input  logic [AW-1:0]        rd_a2_i,
    output logic                 stall_o,
    output logic [(2**AW)-1:0]   busy_o
);

    localparam int NREG = 2 ** AW;
    localparam int PW   = (NREQ > 2) ? 2 : 1;

    logic [PW-1:0]   rr_ptr_q, rr_ptr_d;
    logic            wr_ena_q, wr_ena_d;
    logic [AW-1:0]   wr_adr_q, wr_adr_d;
    logic [DW-1:0]   wr_data_q, wr_data_d;
    logic [NREG-1:0] busy_q, busy_d;

    logic [NREQ-1:0] gnt;
    logic [PW-1:0]   gnt_idx;
    logic            xfer;
    logic [NREG-1:0] wr_clr;
    logic [NREG-1:0] busy_eff;
    logic            stall;

    // Search from the highest offset down so the requester closest to rr_ptr wins.
    always_comb begin
        gnt     = '0;
        gnt_idx = rr_ptr_q;
        for (int k = NREQ - 1; k >= 0; k--) begin
            if (req_valid_i[(int'(rr_ptr_q) + k) % NREQ]) begin
                gnt_idx = PW'((int'(rr_ptr_q) + k) % NREQ);
            end
        end
        xfer = rst_n & (|req_valid_i);
        if (xfer) begin
            gnt[gnt_idx] = 1'b1;
        end
    end

    always_comb begin
        rr_ptr_d  = rr_ptr_q;
        wr_ena_d  = xfer;
        wr_adr_d  = wr_adr_q;
        wr_data_d = wr_data_q;
        if (xfer) begin
            rr_ptr_d  = (gnt_idx == PW'(NREQ - 1)) ? '0 : gnt_idx + PW'(1);
            wr_adr_d  = req_adr_i[int'(gnt_idx) * AW +: AW];
            wr_data_d = req_data_i[int'(gnt_idx) * DW +: DW];
        end
    end

    // A write landing this cycle releases its register immediately for decode.
    always_comb begin
        wr_clr = '0;
        if (wr_ena_q) begin
            wr_clr[wr_adr_q] = 1'b1;
        end
        busy_eff = busy_q & ~wr_clr;
        stall    = (rd_ena_i & (busy_eff[rd_a1_i] | busy_eff[rd_a2_i]))
                 | (sb_set_i & busy_eff[sb_set_adr_i]);
        busy_d   = busy_eff;
        if (sb_set_i && !stall) begin
            busy_d[sb_set_adr_i] = 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr_q  <= '0;
            wr_ena_q  <= 1'b0;
            wr_adr_q  <= '0;
            wr_data_q <= '0;
            busy_q    <= '0;
        end else begin
            rr_ptr_q  <= rr_ptr_d;
            wr_ena_q  <= wr_ena_d;
            wr_adr_q  <= wr_adr_d;
            wr_data_q <= wr_data_d;
            busy_q    <= busy_d;
        end
    end

    assign req_ready_o = gnt;
    assign wr_ena_o    = wr_ena_q;
    assign wr_adr_o    = wr_adr_q;
    assign wr_data_o   = wr_data_q;
    assign stall_o     = stall;
    assign busy_o      = busy_q;

endmodule

// File: tb/tb_regfile_wr_sched.sv
// Directed table-driven bench for regfile_wr_sched, plus a hand-written
// asynchronous-reset sequence.
module tb_regfile_wr_sched;

    localparam int NREQ = 3;
    localparam int DW   = 16;
    localparam int AW   = 3;

    logic                clk_i;
    logic                rst_n;
    logic [NREQ-1:0]     req_valid_i;
    logic [NREQ*AW-1:0]  req_adr_i;
    logic [NREQ*DW-1:0]  req_data_i;
    logic [NREQ-1:0]     req_ready_o;
    logic                wr_ena_o;
    logic [AW-1:0]       wr_adr_o;
    logic [DW-1:0]       wr_data_o;
    logic                sb_set_i;
    logic [AW-1:0]       sb_set_adr_i;
    logic                rd_ena_i;
    logic [AW-1:0]       rd_a1_i;
    logic [AW-1:0]       rd_a2_i;
    logic                stall_o;
    logic [(2**AW)-1:0]  busy_o;

    regfile_wr_sched #(.NREQ(NREQ), .DW(DW), .AW(AW)) dut (
        .clk_i        (clk_i),
        .rst_n        (rst_n),
        .req_valid_i  (req_valid_i),
        .req_adr_i    (req_adr_i),
        .req_data_i   (req_data_i),
        .req_ready_o  (req_ready_o),
        .wr_ena_o     (wr_ena_o),
        .wr_adr_o     (wr_adr_o),
        .wr_data_o    (wr_data_o),
        .sb_set_i     (sb_set_i),
        .sb_set_adr_i (sb_set_adr_i),
        .rd_ena_i     (rd_ena_i),
        .rd_a1_i      (rd_a1_i),
        .rd_a2_i      (rd_a2_i),
        .stall_o      (stall_o),
        .busy_o       (busy_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    typedef struct {
        logic [2:0]  valid;
        logic [8:0]  radr;
        logic [47:0] rdata;
        logic        set;
        logic [2:0]  sadr;
        logic        rd;
        logic [2:0]  a1;
        logic [2:0]  a2;
        logic [2:0]  e_ready;
        logic        e_wena;
        logic [2:0]  e_wadr;
        logic [15:0] e_wdata;
        logic        e_stall;
        logic [7:0]  e_busy;
    } vec_t;

    localparam logic [8:0]  DA  = {3'd3, 3'd2, 3'd1};
    localparam logic [47:0] DD  = {16'h0033, 16'h0022, 16'h0011};
    localparam logic [8:0]  A5  = {3'd3, 3'd5, 3'd1};
    localparam logic [47:0] D5  = {16'h0033, 16'hBEEF, 16'h0011};
    localparam logic [8:0]  A4  = {3'd3, 3'd2, 3'd4};
    localparam logic [47:0] D4  = {16'h0033, 16'h0022, 16'h0044};
    localparam int NV = 23;

    vec_t tbl [NV];
    int   n_checks;
    int   n_err;

    function automatic vec_t mk(
        input logic [2:0] valid, input logic [8:0] radr, input logic [47:0] rdata,
        input logic set, input logic [2:0] sadr, input logic rd, input logic [2:0] a1, input logic [2:0] a2,
        input logic [2:0] e_ready, input logic e_wena, input logic [2:0] e_wadr, input logic [15:0] e_wdata,
        input logic e_stall, input logic [7:0] e_busy);
        vec_t v;
        v.valid = valid; v.radr = radr; v.rdata = rdata;
        v.set = set; v.sadr = sadr; v.rd = rd; v.a1 = a1; v.a2 = a2;
        v.e_ready = e_ready; v.e_wena = e_wena; v.e_wadr = e_wadr; v.e_wdata = e_wdata;
        v.e_stall = e_stall; v.e_busy = e_busy;
        return v;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    initial begin
        n_checks = 0;
        n_err    = 0;

        // round robin with all three valid
        tbl[0]  = mk(3'b111, DA, DD, 0, 0, 0, 0, 0, 3'b001, 0, 0, 16'h0000, 0, 8'h00);
        tbl[1]  = mk(3'b111, DA, DD, 0, 0, 0, 0, 0, 3'b010, 1, 1, 16'h0011, 0, 8'h00);
        tbl[2]  = mk(3'b111, DA, DD, 0, 0, 0, 0, 0, 3'b100, 1, 2, 16'h0022, 0, 8'h00);
        tbl[3]  = mk(3'b111, DA, DD, 0, 0, 0, 0, 0, 3'b001, 1, 3, 16'h0033, 0, 8'h00);
        tbl[4]  = mk(3'b000, DA, DD, 0, 0, 0, 0, 0, 3'b000, 1, 1, 16'h0011, 0, 8'h00);
        tbl[5]  = mk(3'b000, DA, DD, 0, 0, 0, 0, 0, 3'b000, 0, 1, 16'h0011, 0, 8'h00);
        // skip idle requester 1 with rr_ptr=1
        tbl[6]  = mk(3'b101, DA, DD, 0, 0, 0, 0, 0, 3'b100, 0, 1, 16'h0011, 0, 8'h00);
        tbl[7]  = mk(3'b101, DA, DD, 0, 0, 0, 0, 0, 3'b001, 1, 3, 16'h0033, 0, 8'h00);
        tbl[8]  = mk(3'b101, DA, DD, 0, 0, 0, 0, 0, 3'b100, 1, 1, 16'h0011, 0, 8'h00);
        tbl[9]  = mk(3'b000, DA, DD, 0, 0, 0, 0, 0, 3'b000, 1, 3, 16'h0033, 0, 8'h00);
        tbl[10] = mk(3'b000, DA, DD, 0, 0, 0, 0, 0, 3'b000, 0, 3, 16'h0033, 0, 8'h00);
        // RAW on r5
        tbl[11] = mk(3'b000, DA, DD, 1, 5, 0, 0, 0, 3'b000, 0, 3, 16'h0033, 0, 8'h00);
        tbl[12] = mk(3'b000, DA, DD, 0, 0, 1, 5, 0, 3'b000, 0, 3, 16'h0033, 1, 8'h20);
        tbl[13] = mk(3'b010, A5, D5, 0, 0, 1, 5, 0, 3'b010, 0, 3, 16'h0033, 1, 8'h20);
        tbl[14] = mk(3'b000, A5, D5, 0, 0, 1, 5, 0, 3'b000, 1, 5, 16'hBEEF, 0, 8'h20);
        tbl[15] = mk(3'b000, DA, DD, 0, 0, 0, 0, 0, 3'b000, 0, 5, 16'hBEEF, 0, 8'h00);
        // WAW on r3, then set/clear race on r4
        tbl[16] = mk(3'b000, DA, DD, 1, 3, 0, 0, 0, 3'b000, 0, 5, 16'hBEEF, 0, 8'h00);
        tbl[17] = mk(3'b000, DA, DD, 1, 3, 0, 0, 0, 3'b000, 0, 5, 16'hBEEF, 1, 8'h08);
        tbl[18] = mk(3'b001, A4, D4, 1, 4, 0, 0, 0, 3'b001, 0, 5, 16'hBEEF, 0, 8'h08);
        tbl[19] = mk(3'b000, A4, D4, 1, 4, 0, 0, 0, 3'b000, 1, 4, 16'h0044, 0, 8'h18);
        tbl[20] = mk(3'b000, DA, DD, 0, 0, 1, 0, 4, 3'b000, 0, 4, 16'h0044, 1, 8'h18);
        tbl[21] = mk(3'b000, DA, DD, 0, 0, 1, 3, 0, 3'b000, 0, 4, 16'h0044, 1, 8'h18);
        tbl[22] = mk(3'b000, DA, DD, 0, 0, 0, 3, 0, 3'b000, 0, 4, 16'h0044, 0, 8'h18);

        rst_n        = 1'b0;
        req_valid_i  = 3'b111;
        req_adr_i    = DA;
        req_data_i   = DD;
        sb_set_i     = 1'b0;
        sb_set_adr_i = '0;
        rd_ena_i     = 1'b0;
        rd_a1_i      = '0;
        rd_a2_i      = '0;

        @(negedge clk_i);
        @(negedge clk_i);
        #1;
        chk("reset ready", 64'(req_ready_o), 64'h0);
        chk("reset wena",  64'(wr_ena_o),    64'h0);
        chk("reset wadr",  64'(wr_adr_o),    64'h0);
        chk("reset wdata", 64'(wr_data_o),   64'h0);
        chk("reset busy",  64'(busy_o),      64'h0);
        @(negedge clk_i);
        req_valid_i = 3'b000;
        rst_n       = 1'b1;

        for (int i = 0; i < NV; i++) begin
            @(negedge clk_i);
            req_valid_i  = tbl[i].valid;
            req_adr_i    = tbl[i].radr;
            req_data_i   = tbl[i].rdata;
            sb_set_i     = tbl[i].set;
            sb_set_adr_i = tbl[i].sadr;
            rd_ena_i     = tbl[i].rd;
            rd_a1_i      = tbl[i].a1;
            rd_a2_i      = tbl[i].a2;
            #1;
            chk($sformatf("v%0d ready", i), 64'(req_ready_o), 64'(tbl[i].e_ready));
            chk($sformatf("v%0d wena", i),  64'(wr_ena_o),    64'(tbl[i].e_wena));
            chk($sformatf("v%0d wadr", i),  64'(wr_adr_o),    64'(tbl[i].e_wadr));
            chk($sformatf("v%0d wdata", i), 64'(wr_data_o),   64'(tbl[i].e_wdata));
            chk($sformatf("v%0d stall", i), 64'(stall_o),     64'(tbl[i].e_stall));
            chk($sformatf("v%0d busy", i),  64'(busy_o),      64'(tbl[i].e_busy));
        end

        // mid-stream asynchronous reset; rr_ptr is 1 and r3/r4 are reserved here
        @(negedge clk_i);
        req_valid_i = 3'b111;
        req_adr_i   = DA;
        req_data_i  = DD;
        sb_set_i    = 1'b0;
        rd_ena_i    = 1'b0;
        #1;
        chk("pre-reset ready", 64'(req_ready_o), 64'h2);
        @(posedge clk_i);
        #2;
        chk("pre-reset wena", 64'(wr_ena_o), 64'h1);
        chk("pre-reset wadr", 64'(wr_adr_o), 64'h2);
        chk("pre-reset busy", 64'(busy_o),   64'h18);
        rst_n = 1'b0;
        #1;
        chk("async reset ready", 64'(req_ready_o), 64'h0);
        chk("async reset wena",  64'(wr_ena_o),    64'h0);
        chk("async reset wadr",  64'(wr_adr_o),    64'h0);
        chk("async reset wdata", 64'(wr_data_o),   64'h0);
        chk("async reset busy",  64'(busy_o),      64'h0);
        @(negedge clk_i);
        rst_n = 1'b1;
        #1;
        chk("post-reset ready", 64'(req_ready_o), 64'h1);
        @(posedge clk_i);
        #1;
        chk("post-reset wena",  64'(wr_ena_o),  64'h1);
        chk("post-reset wadr",  64'(wr_adr_o),  64'h1);
        chk("post-reset wdata", 64'(wr_data_o), 64'h0011);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
